// File: rtl/rd_tag_allocator.sv
// Destination-register rename tag allocator: issues free tags round-robin from ID
// and tracks in-flight tags until write-back release or pipeline kill.
module rd_tag_allocator #(
  parameter int TAG_WIDTH = 3,
  localparam int NUM_TAGS = 1 << TAG_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  output logic                 tag_full,
  input  logic                 release_en,
  input  logic [TAG_WIDTH-1:0] release_tag,
  input  logic                 kill_en,
  input  logic [NUM_TAGS-1:0]  kill_mask,
  output logic [NUM_TAGS-1:0]  busy_mask,
  output logic [TAG_WIDTH-1:0] free_cnt,
  output logic                 err_release
);

  localparam logic [TAG_WIDTH:0]   WRAP     = (TAG_WIDTH+1)'(NUM_TAGS - 1);
  localparam logic [TAG_WIDTH-1:0] LAST_TAG = TAG_WIDTH'(NUM_TAGS - 1);

  logic [NUM_TAGS-1:0]  busy;
  logic [NUM_TAGS-1:0]  busy_next;
  logic [NUM_TAGS-1:0]  rel_vec;
  logic [NUM_TAGS-1:0]  kill_vec;
  logic [NUM_TAGS-1:0]  alloc_vec;
  logic [TAG_WIDTH-1:0] ptr;
  logic [TAG_WIDTH-1:0] ptr_next;
  logic [TAG_WIDTH-1:0] sel_tag;
  logic [TAG_WIDTH-1:0] free_q;
  logic [TAG_WIDTH-1:0] free_next;
  logic [TAG_WIDTH:0]   cand;
  logic                 found;
  logic                 rel_valid;
  logic                 rel_err;

  // Round-robin search over tags 1..NUM_TAGS-1 starting at ptr; tag 0 is never a candidate.
  always_comb begin
    sel_tag = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_TAGS - 1; k++) begin
      cand = {1'b0, ptr} + (TAG_WIDTH+1)'(k);
      if (cand > WRAP) cand = cand - WRAP;
      if (!found && !busy[cand[TAG_WIDTH-1:0]]) begin
        found   = 1'b1;
        sel_tag = cand[TAG_WIDTH-1:0];
      end
    end
  end

  assign tag_full    = (free_q == '0);
  assign alloc_gnt   = alloc_req & ~tag_full;
  assign alloc_tag   = sel_tag;
  assign busy_mask   = busy;
  assign free_cnt    = free_q;

  assign rel_valid = release_en && (release_tag != '0);
  assign rel_err   = rel_valid && !busy[release_tag];

  always_comb begin
    rel_vec   = '0;
    alloc_vec = '0;
    kill_vec  = '0;
    if (rel_valid && busy[release_tag]) rel_vec[release_tag] = 1'b1;
    if (alloc_gnt) alloc_vec[sel_tag] = 1'b1;
    if (kill_en) kill_vec = kill_mask & ~NUM_TAGS'(1);
    busy_next = (busy & ~rel_vec & ~kill_vec) | alloc_vec;
  end

  // Next free count is recomputed from next busy so it can never drift from the bitmap.
  always_comb begin
    free_next = '0;
    for (int i = 1; i < NUM_TAGS; i++) begin
      if (!busy_next[i]) free_next = free_next + TAG_WIDTH'(1);
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (alloc_gnt) ptr_next = (sel_tag == LAST_TAG) ? TAG_WIDTH'(1) : sel_tag + TAG_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= '0;
      ptr         <= TAG_WIDTH'(1);
      free_q      <= LAST_TAG;
      err_release <= 1'b0;
    end else begin
      busy        <= busy_next;
      ptr         <= ptr_next;
      free_q      <= free_next;
      err_release <= err_release | rel_err;
    end
  end

endmodule

// File: tb/tb_rd_tag_allocator.sv
// Self-checking bench for rd_tag_allocator: directed scenarios followed by
// randomized traffic, all compared against a behavioural tag-pool model.
module tb_rd_tag_allocator;

  localparam int TW = 3;
  localparam int NT = 1 << TW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          alloc_req = 1'b0;
  logic          alloc_gnt;
  logic [TW-1:0] alloc_tag;
  logic          tag_full;
  logic          release_en = 1'b0;
  logic [TW-1:0] release_tag = '0;
  logic          kill_en = 1'b0;
  logic [NT-1:0] kill_mask = '0;
  logic [NT-1:0] busy_mask;
  logic [TW-1:0] free_cnt;
  logic          err_release;

  int checks = 0;
  int errors = 0;

  bit m_busy[NT];
  int m_ptr;
  bit m_err;

  rd_tag_allocator #(.TAG_WIDTH(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag), .tag_full(tag_full),
    .release_en(release_en), .release_tag(release_tag),
    .kill_en(kill_en), .kill_mask(kill_mask),
    .busy_mask(busy_mask), .free_cnt(free_cnt), .err_release(err_release)
  );

  always #5 clk = ~clk;

  function automatic int modelFree();
    int n = 0;
    for (int t = 1; t < NT; t++) if (!m_busy[t]) n++;
    return n;
  endfunction

  function automatic int modelTag();
    for (int k = 0; k < NT - 1; k++) begin
      int t = ((m_ptr - 1 + k) % (NT - 1)) + 1;
      if (!m_busy[t]) return t;
    end
    return 0;
  endfunction

  function automatic logic [NT-1:0] modelMask();
    logic [NT-1:0] m = '0;
    for (int t = 0; t < NT; t++) m[t] = m_busy[t];
    return m;
  endfunction

  task automatic modelReset();
    for (int t = 0; t < NT; t++) m_busy[t] = 1'b0;
    m_ptr = 1;
    m_err = 1'b0;
  endtask

  task automatic checkValue(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic checkOutput(input bit req);
    int ft = modelFree();
    checkValue("tag_full", tag_full, ft == 0);
    checkValue("alloc_gnt", alloc_gnt, req && ft != 0);
    checkValue("alloc_tag", alloc_tag, modelTag());
    checkValue("free_cnt", free_cnt, ft);
    checkValue("busy_mask", busy_mask, modelMask());
    checkValue("err_release", err_release, m_err);
  endtask

  // Model the clock edge from the rules: returns first, grant only from currently free tags.
  task automatic modelStep(input bit req, input bit ren, input int rtag, input bit ken,
                           input logic [NT-1:0] kmask);
    int  t   = modelTag();
    bit  gnt = req && modelFree() != 0;
    bit  nb[NT];
    for (int i = 0; i < NT; i++) nb[i] = m_busy[i];
    if (ren && rtag != 0) begin
      if (m_busy[rtag]) nb[rtag] = 1'b0;
      else m_err = 1'b1;
    end
    if (ken) for (int i = 1; i < NT; i++) if (kmask[i]) nb[i] = 1'b0;
    if (gnt) begin
      nb[t] = 1'b1;
      m_ptr = (t == NT - 1) ? 1 : t + 1;
    end
    for (int i = 0; i < NT; i++) m_busy[i] = nb[i];
  endtask

  // One cycle: drive, check against the model, optionally check an explicit expected tag.
  task automatic applyStimulus(input bit req, input bit ren, input int rtag, input bit ken,
                               input logic [NT-1:0] kmask, input int expTag);
    @(negedge clk);
    alloc_req   = req;
    release_en  = ren;
    release_tag = TW'(rtag);
    kill_en     = ken;
    kill_mask   = kmask;
    #1;
    checkOutput(req);
    if (expTag >= 0) begin
      checkValue("directed_tag", alloc_tag, expTag);
      checkValue("directed_gnt", alloc_gnt, req && expTag != 0);
    end
    modelStep(req, ren, rtag, ken, kmask);
    @(posedge clk);
    #1;
    alloc_req  = 1'b0;
    release_en = 1'b0;
    release_tag = '0;
    kill_en    = 1'b0;
    kill_mask  = '0;
  endtask

  task automatic checkState(input logic [NT-1:0] expBusy, input int expFree, input bit expErr);
    @(negedge clk);
    #1;
    checkValue("state_busy", busy_mask, expBusy);
    checkValue("state_free", free_cnt, expFree);
    checkValue("state_err", err_release, expErr);
  endtask

  task automatic checkResetValues();
    checkValue("rst_tag", alloc_tag, 1);
    checkValue("rst_full", tag_full, 0);
    checkValue("rst_busy", busy_mask, 0);
    checkValue("rst_free", free_cnt, NT - 1);
    checkValue("rst_err", err_release, 0);
    checkValue("rst_gnt", alloc_gnt, alloc_req);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    modelReset();
    checkResetValues();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int rtag;
    int pick;
    modelReset();

    $display("[TB] reset and fill");
    doReset();
    for (int i = 0; i < NT - 1; i++) applyStimulus(1, 0, 0, 0, '0, i + 1);
    applyStimulus(1, 0, 0, 0, '0, 0);
    checkState(8'hFE, 0, 0);

    $display("[TB] full with same-cycle release and request");
    applyStimulus(1, 1, 5, 0, '0, 0);
    applyStimulus(1, 0, 0, 0, '0, 5);
    checkState(8'hFE, 0, 0);

    $display("[TB] kill with simultaneous release");
    applyStimulus(0, 1, 7, 0, '0, -1);
    checkState(8'h7E, 1, 0);
    applyStimulus(0, 1, 4, 1, 8'b0111_0001, -1);
    checkState(8'h0E, 4, 0);

    $display("[TB] release error cases");
    applyStimulus(0, 1, 0, 0, '0, -1);
    checkState(8'h0E, 4, 0);
    applyStimulus(0, 1, 3, 0, '0, -1);
    applyStimulus(0, 1, 3, 0, '0, -1);
    checkState(8'h06, 5, 1);
    applyStimulus(0, 0, 0, 0, '0, -1);
    checkState(8'h06, 5, 1);

    $display("[TB] round-robin after release");
    doReset();
    for (int i = 1; i <= 3; i++) applyStimulus(1, 0, 0, 0, '0, i);
    applyStimulus(1, 1, 2, 0, '0, 4);
    applyStimulus(1, 0, 0, 0, '0, 5);
    applyStimulus(1, 0, 0, 0, '0, 6);
    applyStimulus(1, 0, 0, 0, '0, 7);
    applyStimulus(1, 0, 0, 0, '0, 2);

    $display("[TB] mid-run asynchronous reset");
    doReset();
    for (int i = 1; i <= 4; i++) applyStimulus(1, 0, 0, 0, '0, i);
    checkState(8'h1E, 3, 0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkResetValues();
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1, 0, 0, 0, '0, 1);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      if (n == 200) doReset();
      rtag = int'($urandom_range(0, NT - 1));
      if ($urandom_range(0, 9) != 0) begin
        pick = int'($urandom_range(1, NT - 1));
        for (int k = 0; k < NT - 1; k++) begin
          int t = ((pick - 1 + k) % (NT - 1)) + 1;
          if (m_busy[t]) begin
            rtag = t;
            break;
          end
        end
      end
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rtag,
                    $urandom_range(0, 9) == 0, NT'($urandom_range(0, (1 << NT) - 1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
